// File: rtl/croc_pkg.sv
// Shared SoC types and constants.
// - sbr_obi_req_t / sbr_obi_rsp_t : subordinate-side OBI request / response
// - reg_req_t / reg_rsp_t         : register-interface (regbus) request / response
// - Bridge* localparams           : defaults for croc_obi_reg_bridge
// - idx_width()                   : bits needed to index num items (min 1)
package croc_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  aid;
    logic        a_optional;
    logic        req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [2:0]  rid;
    logic        err;
    logic        r_optional;
    logic        gnt;
    logic        rvalid;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  localparam logic [31:0] BridgeErrData       = 32'hBADC_AB1E;
  localparam int unsigned BridgeTimeoutCycles = 256;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } bridge_state_e;

  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 32'd1) ? unsigned'($clog2(num)) : 32'd1;
  endfunction

endpackage

// File: rtl/croc_obi_reg_bridge.sv
// OBI subordinate to regbus bridge with a response watchdog.
// Each granted OBI transaction becomes one regbus access; the OBI response is returned
// the cycle after regbus ready (or after the watchdog aborts the access).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   obi_req_i     : OBI address phase from the crossbar / demux
//   obi_rsp_o     : OBI grant and response phase (no rready back-pressure)
//   reg_req_o     : regbus request toward register peripherals
//   reg_rsp_i     : regbus response
//   timeout_o     : one-cycle pulse, coincident with the aborted response
module croc_obi_reg_bridge
  import croc_pkg::*;
#(
  parameter int unsigned TimeoutCycles = BridgeTimeoutCycles,
  parameter logic [31:0] ErrData       = BridgeErrData
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t obi_req_i,
  output sbr_obi_rsp_t obi_rsp_o,
  output reg_req_t     reg_req_o,
  input  reg_rsp_t     reg_rsp_i,
  output logic         timeout_o
);

  localparam int unsigned    CntW    = idx_width(TimeoutCycles) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    aid_q, aid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          gnt;

  logic unused_a_optional;
  assign unused_a_optional = obi_req_i.a_optional;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aid_d     = aid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    gnt       = 1'b0;

    unique case (state_q)
      StIdle, StResp: begin
        // Granting in StResp as well gives back-to-back transactions every 2 cycles.
        gnt = obi_req_i.req;
        if (obi_req_i.req) begin
          addr_d  = obi_req_i.addr;
          we_d    = obi_req_i.we;
          be_d    = obi_req_i.be;
          wdata_d = obi_req_i.wdata;
          aid_d   = obi_req_i.aid;
          cnt_d   = '0;
          state_d = StAccess;
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        // ready is checked first so it wins over a simultaneous timeout.
        if (reg_rsp_i.ready) begin
          rdata_d = we_q ? 32'd0 : reg_rsp_i.rdata;
          err_d   = reg_rsp_i.error;
          state_d = StResp;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
          rdata_d   = ErrData;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = StResp;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      aid_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      aid_q     <= aid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    obi_rsp_o            = '0;
    obi_rsp_o.gnt        = gnt;
    obi_rsp_o.rvalid     = (state_q == StResp);
    obi_rsp_o.rdata      = rdata_q;
    obi_rsp_o.rid        = aid_q;
    obi_rsp_o.err        = err_q;
    obi_rsp_o.r_optional = 1'b0;

    reg_req_o       = '0;
    reg_req_o.valid = (state_q == StAccess);
    reg_req_o.addr  = addr_q;
    reg_req_o.write = we_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = be_q;
  end

  assign timeout_o = timeout_q;

endmodule
